// File: rtl/cpu_tb_pkg.sv
// cpu_tb_pkg: state encoding, status codes and defaults shared by the run monitor.
package cpu_tb_pkg;
    typedef enum logic [2:0] {IDLE, HOLD, RUN, DRAIN, DONE} state_t;
    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_X31     = 3'd2;
    localparam logic [2:0] ST_ERR     = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [31:0] DEFAULT_HALT_PC = 32'hFFFF_FFFC;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else if (clr_i) count_q <= '0;
        else if (en_i && count_q != '1) count_q <= count_q + W'(1);
    assign count_o = count_q;
endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: sequences CPU reset/run, detects halt, error or timeout and
// latches a verdict with run statistics.
module cpu_run_monitor import cpu_tb_pkg::*; #(
    parameter int          RESET_CYCLES = 10,
    parameter int          MAX_CYCLES   = 1002,
    parameter int          STALL_LIMIT  = 8,
    parameter logic [31:0] HALT_PC      = DEFAULT_HALT_PC,
    parameter logic [31:0] EXPECT_X31   = 32'h0000_0001,
    parameter bit          CHECK_X31    = 1'b1,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc,
    input  logic [31:0]      iaddr,
    input  logic [3:0]       we,
    input  logic [31:0]      x31,
    input  logic [31:0]      errorbits,
    input  logic [31:0]      wrongaddr,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       status,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] store_count,
    output logic [31:0]      final_x31,
    output logic [31:0]      first_err_addr,
    output logic [31:0]      err_bits
);
    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d, stall_q, stall_d, prev_pc_q, prev_pc_d;
    logic [31:0] err_bits_q, err_bits_d, first_err_q, first_err_d, final_x31_q, final_x31_d;
    logic [2:0]  status_q, status_d;
    logic        pass_q, pass_d, cnt_clr, running, has_err, same_pc, halt, timeout;
    logic        unused_iaddr;

    assign running      = state_q == RUN;
    assign has_err      = errorbits != '0;
    assign same_pc      = pc == prev_pc_q;
    // stall_q is the pre-update count, so LIMIT-2 here means the update reaches LIMIT-1
    assign halt         = pc == HALT_PC || (same_pc && stall_q == 32'(STALL_LIMIT - 2));
    assign timeout      = cycle_count == CNT_W'(MAX_CYCLES - 1);
    assign unused_iaddr = ^iaddr;

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(running), .count_o(cycle_count)
    );
    sat_counter #(.W(CNT_W)) u_stores (
        .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(running && we != '0), .count_o(store_count)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stall_d     = stall_q;
        prev_pc_d   = prev_pc_q;
        err_bits_d  = err_bits_q;
        first_err_d = first_err_q;
        final_x31_d = final_x31_q;
        status_d    = status_q;
        pass_d      = pass_q;
        cnt_clr     = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d     = HOLD;
                hold_d      = 32'(RESET_CYCLES - 1);
                stall_d     = '0;
                prev_pc_d   = '0;
                err_bits_d  = '0;
                first_err_d = '0;
                final_x31_d = '0;
                status_d    = ST_NONE;
                pass_d      = 1'b0;
                cnt_clr     = 1'b1;
            end
            HOLD: begin
                state_d = hold_q == '0 ? RUN : HOLD;
                hold_d  = hold_q - 32'd1;
            end
            RUN: begin
                err_bits_d  = err_bits_q | errorbits;
                first_err_d = has_err && err_bits_q == '0 ? wrongaddr : first_err_q;
                stall_d     = same_pc ? stall_q + 32'd1 : '0;
                prev_pc_d   = pc;
                status_d    = has_err ? ST_ERR :
                              halt    ? ((!CHECK_X31 || x31 == EXPECT_X31) ? ST_PASS : ST_X31) :
                              timeout ? ST_TIMEOUT : ST_NONE;
                if (has_err || halt || timeout) begin
                    final_x31_d = x31;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
                pass_d  = status_q == ST_PASS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            stall_q     <= '0;
            prev_pc_q   <= '0;
            err_bits_q  <= '0;
            first_err_q <= '0;
            final_x31_q <= '0;
            status_q    <= ST_NONE;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_q     <= stall_d;
            prev_pc_q   <= prev_pc_d;
            err_bits_q  <= err_bits_d;
            first_err_q <= first_err_d;
            final_x31_q <= final_x31_d;
            status_q    <= status_d;
            pass_q      <= pass_d;
        end

    assign cpu_rst        = state_q != RUN;
    assign busy           = state_q == HOLD || state_q == RUN || state_q == DRAIN;
    assign done           = state_q == DONE;
    assign pass           = pass_q;
    assign status         = status_q;
    assign final_x31      = final_x31_q;
    assign first_err_addr = first_err_q;
    assign err_bits       = err_bits_q;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: two monitors (x31 checked / ignored) driven alike and compared
// every cycle against a phase-level model, plus literal end-of-run expectations.
module tb_cpu_run_monitor;
    localparam int          RC   = 10;
    localparam int          MAXC = 50;
    localparam int          SL   = 8;
    localparam logic [31:0] HALT = 32'hFFFF_FFFC;
    localparam logic [31:0] EXP  = 32'h1;

    logic clk = 1'b0, rst, start;
    logic [31:0] pc, iaddr, x31, errorbits, wrongaddr;
    logic [3:0] we;
    logic [1:0] cpu_rst_w, busy_w, done_w, pass_w;
    logic [1:0][2:0] status_w;
    logic [1:0][31:0] cyc_w, sto_w, fx_w, fa_w, eb_w;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    cpu_run_monitor #(.MAX_CYCLES(MAXC), .CHECK_X31(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .iaddr(iaddr), .we(we), .x31(x31),
        .errorbits(errorbits), .wrongaddr(wrongaddr), .cpu_rst(cpu_rst_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .status(status_w[0]), .cycle_count(cyc_w[0]),
        .store_count(sto_w[0]), .final_x31(fx_w[0]), .first_err_addr(fa_w[0]), .err_bits(eb_w[0])
    );
    cpu_run_monitor #(.MAX_CYCLES(MAXC), .CHECK_X31(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .iaddr(iaddr), .we(we), .x31(x31),
        .errorbits(errorbits), .wrongaddr(wrongaddr), .cpu_rst(cpu_rst_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .status(status_w[1]), .cycle_count(cyc_w[1]),
        .store_count(sto_w[1]), .final_x31(fx_w[1]), .first_err_addr(fa_w[1]), .err_bits(eb_w[1])
    );

    // phase: 0 idle, 1 holding, 2 running, 3 draining, 4 done
    int ph[2], hold_left[2], rep[2];
    logic [31:0] run_n[2], stores[2], err_or[2], faddr[2], fx31[2], last_pc[2];
    logic [2:0] st[2], code;
    logic ps[2];

    task automatic mclr(input int i);
        hold_left[i] = RC; rep[i] = 0; run_n[i] = 0; stores[i] = 0; err_or[i] = 0;
        faddr[i] = 0; fx31[i] = 0; last_pc[i] = 0; st[i] = 0; ps[i] = 1'b0;
    endtask

    always @(posedge clk or posedge rst)
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0;
                mclr(i);
            end else if (ph[i] == 0 || ph[i] == 4) begin
                if (start) begin ph[i] = 1; mclr(i); end
            end else if (ph[i] == 1) begin
                hold_left[i]--;
                if (hold_left[i] == 0) ph[i] = 2;
            end else if (ph[i] == 2) begin
                run_n[i]++;
                if (we != 0) stores[i]++;
                if (errorbits != 0 && err_or[i] == 0) faddr[i] = wrongaddr;
                err_or[i] |= errorbits;
                rep[i] = (pc == last_pc[i]) ? rep[i] + 1 : 0;
                last_pc[i] = pc;
                code = errorbits != 0 ? 3'd3 :
                       (pc == HALT || rep[i] == SL - 1) ? ((i == 1 || x31 == EXP) ? 3'd1 : 3'd2) :
                       run_n[i] == MAXC ? 3'd4 : 3'd0;
                if (code != 0) begin st[i] = code; fx31[i] = x31; ph[i] = 3; end
            end else begin
                ph[i] = 4;
                ps[i] = st[i] == 1;
            end
        end

    task automatic cmp(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, i, $time, got, exp);
        end
    endtask

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            cmp("cpu_rst", i, 32'(cpu_rst_w[i]), 32'(ph[i] != 2));
            cmp("busy", i, 32'(busy_w[i]), 32'(ph[i] >= 1 && ph[i] <= 3));
            cmp("done", i, 32'(done_w[i]), 32'(ph[i] == 4));
            cmp("pass", i, 32'(pass_w[i]), 32'(ps[i]));
            cmp("status", i, 32'(status_w[i]), 32'(st[i]));
            cmp("cycle_count", i, cyc_w[i], run_n[i]);
            cmp("store_count", i, sto_w[i], stores[i]);
            cmp("final_x31", i, fx_w[i], fx31[i]);
            cmp("first_err_addr", i, fa_w[i], faddr[i]);
            cmp("err_bits", i, eb_w[i], err_or[i]);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [3:0] w, input logic [31:0] e, input logic [31:0] a);
        pc = p; iaddr = p; we = w; errorbits = e; wrongaddr = a;
        tick();
    endtask

    task automatic start_run();
        int n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cpu_rst_w[0] && n < 40) begin tick(); n++; end
        cmp("hold_cycles", 0, 32'(n), 32'd10);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done_w[0] && n < 100) begin tick(); n++; end
        cmp({nm, "_done"}, 0, 32'(done_w[0]), 32'd1);
    endtask

    task automatic expect_done(input int i, input logic [2:0] s, input logic p, input logic [31:0] c,
                               input logic [31:0] sc, input logic [31:0] fx);
        cmp("lit_status", i, 32'(status_w[i]), 32'(s));
        cmp("lit_pass", i, 32'(pass_w[i]), 32'(p));
        cmp("lit_cycles", i, cyc_w[i], c);
        cmp("lit_stores", i, sto_w[i], sc);
        cmp("lit_final_x31", i, fx_w[i], fx);
        cmp("lit_cpu_rst", i, 32'(cpu_rst_w[i]), 32'd1);
    endtask

    // six advancing pcs with three stores, then a tight loop at 0x200
    task automatic pass_prog(input logic poke_start);
        for (int k = 1; k <= 6; k++) begin
            start = poke_start && k == 3;
            drive(32'h100 + 32'(4 * k), (k == 2 || k == 4 || k == 5) ? 4'hF : 4'h0, 0, 0);
        end
        start = 1'b0;
        pc = 32'h200; iaddr = 32'h200; we = 4'h0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x31 = 32'h1;
        pc = 0; iaddr = 0; we = 0; errorbits = 0; wrongaddr = 0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            cmp("rst_cpu_rst", i, 32'(cpu_rst_w[i]), 32'd1);
            cmp("rst_busy", i, 32'(busy_w[i]), 32'd0);
            cmp("rst_cycles", i, cyc_w[i], 32'd0);
        end
        rst = 1'b0;
        tick();

        start_run();
        pass_prog(1'b0);
        wait_done("pass");
        for (int i = 0; i < 2; i++) expect_done(i, 3'd1, 1'b1, 32'd14, 32'd3, 32'd1);

        x31 = 32'h5;
        start_run();
        pass_prog(1'b1);
        wait_done("mismatch");
        expect_done(0, 3'd2, 1'b0, 32'd14, 32'd3, 32'd5);
        expect_done(1, 3'd1, 1'b1, 32'd14, 32'd3, 32'd5);

        x31 = 32'h1;
        start_run();
        for (int k = 1; k <= 19; k++) drive(32'h300 + 32'(4 * k), 4'h0, 0, 0);
        drive(32'h350, 4'h0, 32'h4, 32'h123);
        errorbits = 32'h1; wrongaddr = 32'h456;
        wait_done("error");
        errorbits = 0; wrongaddr = 0;
        for (int i = 0; i < 2; i++) begin
            expect_done(i, 3'd3, 1'b0, 32'd20, 32'd0, 32'd1);
            cmp("lit_first_err", i, fa_w[i], 32'h123);
            cmp("lit_err_bits", i, eb_w[i], 32'h4);
        end

        start_run();
        for (int k = 1; k <= 80 && !done_w[0]; k++) drive(32'h1000 + 32'(4 * k), 4'h0, 0, 0);
        cmp("timeout_done", 0, 32'(done_w[0]), 32'd1);
        for (int i = 0; i < 2; i++) expect_done(i, 3'd4, 1'b0, 32'd50, 32'd0, 32'd1);

        start_run();
        for (int k = 1; k <= 5; k++) drive(32'h2000 + 32'(4 * k), 4'hF, 0, 0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            cmp("abort_cpu_rst", i, 32'(cpu_rst_w[i]), 32'd1);
            cmp("abort_busy", i, 32'(busy_w[i]), 32'd0);
            cmp("abort_stores", i, sto_w[i], 32'd0);
            cmp("abort_status", i, 32'(status_w[i]), 32'd0);
        end
        tick();
        rst = 1'b0;
        tick();

        start_run();
        for (int k = 1; k <= 3; k++) drive(32'h100 + 32'(4 * k), 4'h0, 0, 0);
        pc = HALT; iaddr = HALT;
        wait_done("halt_pc");
        for (int i = 0; i < 2; i++) expect_done(i, 3'd1, 1'b1, 32'd4, 32'd0, 32'd1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Synthesizable run controller and self-checker for the pipelined CPU. It replaces the fixed-delay reset/run/reset stimulus with a parametrised sequencer that:
- holds the CPU in reset for a programmable time;
- runs the program;
- detects halt, timeout or error;
- re-asserts CPU reset and latches a pass/fail verdict with statistics.

It sits beside the CPU, imem and dmem, and drives the CPU's rst input. It also runs on the FPGA board.

Parameters:
RESET_CYCLES, 10, cycles cpu_rst held high after start (min 1)
MAX_CYCLES, 1002, run-phase cycle budget before timeout
STALL_LIMIT, 8, consecutive cycles of unchanged pc that mean halt (min 2)
HALT_PC, 32'hFFFF_FFFC, pc value that means immediate halt
EXPECT_X31, 32'h0000_0001, x31 value required for pass
CHECK_X31, 1, 1 = compare x31 at halt, 0 = ignore x31
CNT_W, 32, width of cycle and store counters

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
pc  input  32  CPU pc
iaddr  input  32  CPU instruction address
we  input  4  CPU data-write byte enables
x31  input  32  CPU register x31
errorbits  input  32  CPU error flags
wrongaddr  input  32  CPU faulting address
cpu_rst  output  1  reset to CPU, active-high
busy  output  1  high in HOLD, RUN or DRAIN
done  output  1  high in DONE
pass  output  1  valid when done
status  output  3  0 none, 1 pass, 2 x31 mismatch, 3 cpu error, 4 timeout
cycle_count  output  CNT_W  run-phase cycles
store_count  output  CNT_W  run-phase cycles with we != 0
final_x31  output  32  x31 sampled at end of run
first_err_addr  output  32  wrongaddr at first nonzero errorbits
err_bits  output  32  OR of all errorbits seen during run

Behaviour:
- Reset (async, any state): state IDLE, cpu_rst=1. All other outputs and counters are 0; internal prev_pc=0, stall=0.
- IDLE: cpu_rst=1. On start, clear counters, err_bits, first_err_addr, final_x31, status and pass; load hold counter; go to HOLD.
- HOLD: cpu_rst=1 for exactly RESET_CYCLES cycles. cpu_rst falls on the edge where HOLD moves to RUN.
- RUN: cpu_rst=0. Every cycle:
  - cycle_count++.
  - store_count++ if we!=0.
  - err_bits |= errorbits.
  - If errorbits!=0 and err_bits==0 before this cycle, latch first_err_addr=wrongaddr.
  - stall: increments when pc==prev_pc, else clears; then prev_pc<=pc.
- RUN exit, evaluated in priority order on the same edge:
  1. errorbits!=0 → status 3.
  2. pc==HALT_PC, or stall reaches STALL_LIMIT-1 while pc==prev_pc → halt. status 1 if (!CHECK_X31 or x31==EXPECT_X31), else 2.
  3. cycle_count reaches MAX_CYCLES-1 → status 4.
- On RUN exit: final_x31<=x31, go to DRAIN.
- DRAIN: one cycle, cpu_rst=1, counters frozen. Then go to DONE; pass=(status==1).
- DONE: cpu_rst=1, results held stable. start re-enters HOLD with the same clearing as from IDLE.
- start is ignored in HOLD, RUN and DRAIN.
- Counters saturate at all-ones and never wrap.
- iaddr is informational only. A future retired-instruction counter attaches here; no behaviour is defined on it now.
- Outputs are registered; no combinational path from inputs to outputs.
- rst asserted mid-run aborts to IDLE immediately. No verdict is retained.

Decomposition:
- Shared package cpu_tb_pkg:
  - state encoding IDLE/HOLD/RUN/DRAIN/DONE;
  - status code constants ST_NONE, ST_PASS, ST_X31, ST_ERR, ST_TIMEOUT;
  - default HALT_PC.
- One natural sub-module: sat_counter (parametrised width, clear, enable, saturating). Instantiated twice, for cycle_count and store_count.

Test Plan:
- Reset/hold: rst high then low, start pulse → cpu_rst stays 1 for 10 cycles after start, drops on cycle 11, busy=1 throughout.
- Normal pass: program advances pc, stores 3 times, then loops on one pc with x31=1 → after 8 stalled cycles DRAIN then DONE, status=1, pass=1, store_count=3, final_x31=1.
- x31 mismatch: same as above with x31=5 → status=2, pass=0, final_x31=5. With CHECK_X31=0 → status=1.
- CPU error: errorbits=32'h4 with wrongaddr=32'h0000_0123 at run cycle 20, then errorbits=32'h1 → exits at cycle 20, status=3, first_err_addr=32'h123, err_bits=32'h4, cycle_count=20.
- Timeout: pc increments every cycle, MAX_CYCLES=50 → exits after 50 run cycles, status=4, cycle_count=50, cpu_rst=1 in DRAIN and DONE.
- Abort and rerun: rst pulse in RUN → IDLE, all outputs 0. A second start from DONE clears stats, and start pulses during RUN are ignored.
